// File: rtl/quad_sweep_nco_if.sv
// Control/config and reference outputs exchanged between the register block
// (master) and the quadrature sweep NCO (slave).
interface quad_sweep_nco_if #(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 24,
    parameter int STEP_W  = 16
);
    logic                start;
    logic                abort;
    logic [PHASE_W-1:0]  ftw_start;
    logic [PHASE_W-1:0]  ftw_step;
    logic [STEP_W-1:0]   num_steps;
    logic [CNT_W-1:0]    dwell_cycles;
    logic signed [7:0]   ref_sig;
    logic signed [7:0]   ref_sig_q;
    logic                trigger;
    logic [PHASE_W-1:0]  ftw_current;
    logic [STEP_W-1:0]   step_index;
    logic                busy;
    logic                done;

    modport master (
        output start, abort, ftw_start, ftw_step, num_steps, dwell_cycles,
        input  ref_sig, ref_sig_q, trigger, ftw_current, step_index, busy, done
    );

    modport slave (
        input  start, abort, ftw_start, ftw_step, num_steps, dwell_cycles,
        output ref_sig, ref_sig_q, trigger, ftw_current, step_index, busy, done
    );
endinterface

// File: rtl/quad_sweep_nco.sv
// Phase-accumulator NCO with quarter-wave sine LUT producing an I/Q reference
// pair, plus a sweep FSM that steps the tuning word and strobes trigger per dwell.
module quad_sweep_nco #(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 24,
    parameter int STEP_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    quad_sweep_nco_if.slave  bus
);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t              state, state_next;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  ftw, ftw_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [CNT_W-1:0]    dwell_lat, dwell_lat_next;
    logic [STEP_W-1:0]   step, step_next;
    logic [STEP_W-1:0]   last_step, last_step_next;
    logic                trig, trig_next;
    logic                done_r, done_next;
    logic signed [7:0]   ref_i, ref_q;
    logic                accept;
    logic                dwell_end;
    logic                is_last;
    logic [7:0]          addr;

    function automatic logic [6:0] lut_entry(input logic [5:0] k);
        logic [6:0] v;
        v = '0;
        case (k)
            6'd0:  v = 7'd2;
            6'd1:  v = 7'd5;
            6'd2:  v = 7'd8;
            6'd3:  v = 7'd11;
            6'd4:  v = 7'd14;
            6'd5:  v = 7'd17;
            6'd6:  v = 7'd20;
            6'd7:  v = 7'd23;
            6'd8:  v = 7'd26;
            6'd9:  v = 7'd29;
            6'd10: v = 7'd32;
            6'd11: v = 7'd35;
            6'd12: v = 7'd38;
            6'd13: v = 7'd41;
            6'd14: v = 7'd44;
            6'd15: v = 7'd47;
            6'd16: v = 7'd50;
            6'd17: v = 7'd53;
            6'd18: v = 7'd56;
            6'd19: v = 7'd58;
            6'd20: v = 7'd61;
            6'd21: v = 7'd64;
            6'd22: v = 7'd67;
            6'd23: v = 7'd69;
            6'd24: v = 7'd72;
            6'd25: v = 7'd74;
            6'd26: v = 7'd77;
            6'd27: v = 7'd79;
            6'd28: v = 7'd82;
            6'd29: v = 7'd84;
            6'd30: v = 7'd86;
            6'd31: v = 7'd89;
            6'd32: v = 7'd91;
            6'd33: v = 7'd93;
            6'd34: v = 7'd95;
            6'd35: v = 7'd97;
            6'd36: v = 7'd99;
            6'd37: v = 7'd101;
            6'd38: v = 7'd103;
            6'd39: v = 7'd105;
            6'd40: v = 7'd106;
            6'd41: v = 7'd108;
            6'd42: v = 7'd110;
            6'd43: v = 7'd111;
            6'd44: v = 7'd113;
            6'd45: v = 7'd114;
            6'd46: v = 7'd115;
            6'd47: v = 7'd117;
            6'd48: v = 7'd118;
            6'd49: v = 7'd119;
            6'd50: v = 7'd120;
            6'd51: v = 7'd121;
            6'd52: v = 7'd122;
            6'd53: v = 7'd123;
            6'd54: v = 7'd124;
            6'd55: v = 7'd124;
            6'd56: v = 7'd125;
            6'd57: v = 7'd125;
            6'd58: v = 7'd126;
            6'd59: v = 7'd126;
            6'd60: v = 7'd127;
            6'd61: v = 7'd127;
            6'd62: v = 7'd127;
            6'd63: v = 7'd127;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Odd quadrants read the table mirrored (63-k == ~k), upper half negates.
    function automatic logic [7:0] sine_of(input logic [7:0] a);
        logic [5:0] k;
        logic [7:0] mag;
        k   = a[6] ? ~a[5:0] : a[5:0];
        mag = {1'b0, lut_entry(k)};
        return a[7] ? (~mag + 8'd1) : mag;
    endfunction

    assign accept    = (state == IDLE) && bus.start && !bus.abort;
    assign dwell_end = (cnt == dwell_lat - CNT_W'(1));
    assign is_last   = (step == last_step);
    assign addr      = phase[PHASE_W-1 -: 8];

    // State and sweep registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ftw       <= '0;
            cnt       <= '0;
            dwell_lat <= '0;
            step      <= '0;
            last_step <= '0;
            trig      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_next;
            ftw       <= ftw_next;
            cnt       <= cnt_next;
            dwell_lat <= dwell_lat_next;
            step      <= step_next;
            last_step <= last_step_next;
            trig      <= trig_next;
            done_r    <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DWELL;
            DWELL: begin
                if (bus.abort)                 state_next = IDLE;
                else if (dwell_end && is_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ftw_next       = ftw;
        cnt_next       = cnt;
        dwell_lat_next = dwell_lat;
        step_next      = step;
        last_step_next = last_step;
        trig_next      = 1'b0;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ftw_next       = bus.ftw_start;
                    cnt_next       = '0;
                    step_next      = '0;
                    trig_next      = 1'b1;
                    dwell_lat_next = (bus.dwell_cycles < CNT_W'(2)) ? CNT_W'(2) : bus.dwell_cycles;
                    // Stored as the index of the final step; zero steps means one.
                    last_step_next = (bus.num_steps == '0) ? '0 : bus.num_steps - STEP_W'(1);
                end
            end
            DWELL: begin
                if (!bus.abort) begin
                    if (dwell_end) begin
                        trig_next = 1'b1;
                        if (is_last) begin
                            done_next = 1'b1;
                        end else begin
                            ftw_next  = ftw + bus.ftw_step;
                            step_next = step + STEP_W'(1);
                            cnt_next  = '0;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // NCO runs in every state; only an accepted start realigns it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
            ref_i <= '0;
            ref_q <= '0;
        end else begin
            phase <= accept ? '0 : phase + ftw;
            ref_i <= sine_of(addr);
            ref_q <= sine_of(addr + 8'd64);
        end
    end

    assign bus.ref_sig     = ref_i;
    assign bus.ref_sig_q   = ref_q;
    assign bus.trigger     = trig;
    assign bus.done        = done_r;
    assign bus.ftw_current = ftw;
    assign bus.step_index  = step;
    assign bus.busy        = (state == DWELL);

endmodule

// File: tb/tb_quad_sweep_nco.sv
// Directed bench for quad_sweep_nco: expected trigger events are queued when a
// sweep is launched and popped by a monitor as the DUT strobes trigger/done.
module tb_quad_sweep_nco;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    quad_sweep_nco_if #(.PHASE_W(32), .CNT_W(24), .STEP_W(16)) bus ();

    quad_sweep_nco #(.PHASE_W(32), .CNT_W(24), .STEP_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          at;
        logic [31:0] ftw;
        logic [15:0] step;
        logic        done;
    } trig_t;

    trig_t exp_q[$];
    trig_t mon_t;
    int    cyc = 0;
    int    vectors = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference sine built from the closed-form table definition.
    function automatic logic signed [7:0] lut_model(input logic [7:0] a);
        int  k;
        int  l;
        real v;
        k = int'(a[5:0]);
        if (a[6]) k = 63 - k;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.5) / 256.0);
        l = $rtoi(v + 0.5);
        if (a[7]) l = -l;
        return 8'(l);
    endfunction

    always @(negedge clk) begin
        if (reset_n && (bus.trigger || bus.done)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", {30'b0, bus.trigger, bus.done}, 32'd0);
            end else begin
                mon_t = exp_q.pop_front();
                chk("trig_cycle", cyc, mon_t.at);
                chk("trig_trigger", {31'b0, bus.trigger}, 32'd1);
                chk("trig_done", {31'b0, bus.done}, {31'b0, mon_t.done});
                chk("trig_ftw", bus.ftw_current, mon_t.ftw);
                chk("trig_step", {16'b0, bus.step_index}, {16'b0, mon_t.step});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Launches a sweep at the current negedge; pushes up to 'keep' expected
    // trigger events (keep < 0 means all). Returns the cycle of the first trigger.
    task automatic start_sweep(input logic [31:0] f0, input logic [31:0] st,
                               input logic [15:0] n, input logic [23:0] d,
                               input int keep, output int a);
        int nn;
        int dd;
        int j;
        trig_t t;
        nn = (n == 16'd0) ? 1 : int'(n);
        dd = (d < 24'd2) ? 2 : int'(d);
        bus.ftw_start    = f0;
        bus.ftw_step     = st;
        bus.num_steps    = n;
        bus.dwell_cycles = d;
        bus.start        = 1'b1;
        a = cyc + 1;
        for (int i = 0; i <= nn; i++) begin
            if (keep < 0 || i < keep) begin
                j      = (i < nn) ? i : nn - 1;
                t.at   = a + i * dd;
                t.ftw  = f0 + 32'(j) * st;
                t.step = 16'(j);
                t.done = (i == nn);
                exp_q.push_back(t);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Checks ref outputs over the first dwell window (phase starts at 0).
    task automatic check_window(input logic [31:0] f0, input int dwell);
        logic [31:0] ph;
        for (int m = 1; m <= dwell; m++) begin
            @(negedge clk);
            ph = 32'(m - 1) * f0;
            chk("ref_sig", 32'(bus.ref_sig), 32'(lut_model(ph[31:24])));
            chk("ref_sig_q", 32'(bus.ref_sig_q), 32'(lut_model(ph[31:24] + 8'd64)));
            if (m < dwell) chk("busy_in_window", {31'b0, bus.busy}, 32'd1);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || bus.busy); i++) @(negedge clk);
        chk("sweep_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int a;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ftw_start = '0;
        bus.ftw_step = '0;
        bus.num_steps = '0;
        bus.dwell_cycles = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ref_sig", 32'(bus.ref_sig), 32'd0);
        chk("rst_ref_sig_q", 32'(bus.ref_sig_q), 32'd0);
        chk("rst_trigger", {31'b0, bus.trigger}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_ftw", bus.ftw_current, 32'd0);
        chk("rst_step", {16'b0, bus.step_index}, 32'd0);

        // Idle after release: phase parked at 0
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ref_sig", 32'(bus.ref_sig), 32'sd2);
        chk("idle_ref_sig_q", 32'(bus.ref_sig_q), 32'sd127);
        chk("idle_busy", {31'b0, bus.busy}, 32'd0);
        chk("idle_ftw", bus.ftw_current, 32'd0);

        // Quarter-rate tone, single step, dwell 8
        start_sweep(32'h4000_0000, 32'h0, 16'd1, 24'd8, -1, a);
        check_window(32'h4000_0000, 8);
        chk("quarter_busy_end", {31'b0, bus.busy}, 32'd0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("quarter_ftw_hold", bus.ftw_current, 32'h4000_0000);

        // Upward three-step sweep
        start_sweep(32'h1000_0000, 32'h0800_0000, 16'd3, 24'd10, -1, a);
        check_window(32'h1000_0000, 10);
        wait_idle();
        chk("up_ftw_final", bus.ftw_current, 32'h2000_0000);
        chk("up_step_final", {16'b0, bus.step_index}, 32'd2);

        // Negative step wrapping through zero
        start_sweep(32'h0000_0100, 32'hFFFF_FF00, 16'd3, 24'd4, -1, a);
        wait_idle();
        chk("neg_ftw_final", bus.ftw_current, 32'hFFFF_FF00);

        // Abort during step 1; a start while busy must be ignored
        start_sweep(32'h0200_0000, 32'h0100_0000, 16'd4, 24'd6, 2, a);
        repeat (2) @(negedge clk);
        bus.ftw_start = 32'h7000_0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_busy", {31'b0, bus.busy}, 32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_step", {16'b0, bus.step_index}, 32'd1);
        chk("abort_ftw", bus.ftw_current, 32'h0300_0000);
        repeat (20) @(negedge clk);
        chk("abort_ftw_hold", bus.ftw_current, 32'h0300_0000);
        chk("abort_drained", exp_q.size(), 32'd0);

        // start and abort together in IDLE: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy", {31'b0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Degenerate config: zero steps, dwell 1
        start_sweep(32'h0100_0000, 32'h0, 16'd0, 24'd1, -1, a);
        wait_idle();

        // Reset mid-sweep
        start_sweep(32'h2000_0000, 32'h0000_1000, 16'd2, 24'd20, 1, a);
        repeat (5) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_ref_sig", 32'(bus.ref_sig), 32'd0);
        chk("midrst_ref_sig_q", 32'(bus.ref_sig_q), 32'd0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_ftw", bus.ftw_current, 32'd0);
        chk("midrst_trigger", {31'b0, bus.trigger}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
